// File: rtl/lda_pixel_writer.sv
// Pixel-stream sink: plot strobes are buffered in a FIFO, linearised to a
// framebuffer address and written out over a wait-request port.
// Optional LDA_PIXEL_CLIP_EN drops off-screen plots at the FIFO input.
module lda_pixel_writer #(
  parameter int DEPTH    = 8,
  parameter int SCREEN_W = 320,
  parameter int SCREEN_H = 240
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_PLOT,
  input  logic [8:0]  i_X,
  input  logic [8:0]  i_Y,
  input  logic [2:0]  i_COLOR,
  output logic        o_FULL,
  output logic        o_IDLE,
  output logic        o_OVERFLOW,
  output logic        o_WR_EN,
  output logic [16:0] o_ADDR,
  output logic [2:0]  o_DATA,
  input  logic        i_WAITREQUEST
);

  localparam int AW = $clog2(DEPTH);

  typedef struct packed {
    logic [8:0] x;
    logic [8:0] y;
    logic [2:0] color;
  } pix_t;

  pix_t          mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count;

  logic  full, empty, in_range, push, pop, xfer;
  pix_t  head;
  logic [16:0] head_addr;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);

`ifdef LDA_PIXEL_CLIP_EN
  assign in_range = (32'(i_X) < SCREEN_W) && (32'(i_Y) < SCREEN_H);
`else
  assign in_range = 1'b1;
`endif

  // Full is judged on the registered count, so a same-cycle pop never
  // makes room for a plot that arrives while full.
  assign push = i_PLOT && in_range && !full;
  assign xfer = o_WR_EN && !i_WAITREQUEST;
  assign pop  = !empty && (!o_WR_EN || xfer);

  assign head      = mem[rptr];
  // 17-bit arithmetic gives the modulo-2^17 wrap for free
  assign head_addr = 17'(head.y) * 17'(SCREEN_W) + 17'(head.x);

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= '{x: i_X, y: i_Y, color: i_COLOR};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr       <= '0;
      rptr       <= '0;
      count      <= '0;
      o_OVERFLOW <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (i_PLOT && in_range && full) o_OVERFLOW <= 1'b1;
    end
  end

  // Output register: one outstanding framebuffer write, held under wait.
  always_ff @(posedge clk) begin
    if (reset) begin
      o_WR_EN <= 1'b0;
      o_ADDR  <= '0;
      o_DATA  <= '0;
    end else if (pop) begin
      o_WR_EN <= 1'b1;
      o_ADDR  <= head_addr;
      o_DATA  <= head.color;
    end else if (xfer) begin
      o_WR_EN <= 1'b0;
    end
  end

  assign o_FULL = full;
  assign o_IDLE = empty && !o_WR_EN;

endmodule

// File: tb/tb_lda_pixel_writer.sv
// Bench for lda_pixel_writer: directed plan steps plus random traffic,
// checked against a queue-level model of buffered and pending pixels.
module tb_lda_pixel_writer;
  localparam int DEPTH = 8;
  localparam int SW = 320;
  localparam int SH = 240;

  logic        clk = 1'b0;
  logic        reset, i_PLOT, i_WAITREQUEST;
  logic [8:0]  i_X, i_Y;
  logic [2:0]  i_COLOR;
  logic        o_FULL, o_IDLE, o_OVERFLOW, o_WR_EN;
  logic [16:0] o_ADDR;
  logic [2:0]  o_DATA;

  lda_pixel_writer #(.DEPTH(DEPTH), .SCREEN_W(SW), .SCREEN_H(SH)) dut (
    .clk(clk), .reset(reset), .i_PLOT(i_PLOT), .i_X(i_X), .i_Y(i_Y),
    .i_COLOR(i_COLOR), .o_FULL(o_FULL), .o_IDLE(o_IDLE),
    .o_OVERFLOW(o_OVERFLOW), .o_WR_EN(o_WR_EN), .o_ADDR(o_ADDR),
    .o_DATA(o_DATA), .i_WAITREQUEST(i_WAITREQUEST)
  );

  always #5 clk = ~clk;

  typedef struct {
    int x;
    int y;
    int c;
  } pix_t;

  pix_t fq[$];
  pix_t pend;
  bit   pend_v;
  bit   ovf_m;
  int   n_chk, n_fail;
  int   n_wr;
  int   last_addr;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int addr_of(input pix_t p);
    return (p.y * SW + p.x) % 131072;
  endfunction

  function automatic bit on_screen(input int x, input int y);
`ifdef LDA_PIXEL_CLIP_EN
    return (x < SW) && (y < SH);
`else
    return 1'b1;
`endif
  endfunction

  // Called at a negedge; compares state, applies inputs for this cycle,
  // advances the model across the next posedge, returns at the next negedge.
  task automatic cyc(input bit plot, input int x, input int y, input int c,
                     input bit wt, input bit rst);
    bit   full_m, xfer_m;
    pix_t np;
    full_m = (fq.size() == DEPTH);
    chk("wr_en", int'(o_WR_EN), int'(pend_v));
    if (pend_v) begin
      chk("addr", int'(o_ADDR), addr_of(pend));
      chk("data", int'(o_DATA), pend.c);
    end
    chk("full", int'(o_FULL), int'(full_m));
    chk("idle", int'(o_IDLE), int'(fq.size() == 0 && !pend_v));
    chk("overflow", int'(o_OVERFLOW), int'(ovf_m));
    reset = rst; i_PLOT = plot; i_X = 9'(x); i_Y = 9'(y); i_COLOR = 3'(c);
    i_WAITREQUEST = wt;
    if (!rst && o_WR_EN && !wt) begin
      n_wr++;
      last_addr = int'(o_ADDR);
    end
    if (rst) begin
      fq.delete(); pend_v = 0; ovf_m = 0;
    end else begin
      xfer_m = pend_v && !wt;
      np = '{x: x, y: y, c: c};
      if (plot && on_screen(x, y) && full_m) ovf_m = 1;
      if (fq.size() != 0 && (!pend_v || xfer_m)) begin
        pend = fq.pop_front(); pend_v = 1;
      end else if (xfer_m) pend_v = 0;
      if (plot && on_screen(x, y) && !full_m) fq.push_back(np);
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_cycles(input int n, input bit wt);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, wt, 0);
  endtask

  initial begin
    int w0;
    n_chk = 0; n_fail = 0; n_wr = 0; last_addr = -1;
    pend_v = 0; ovf_m = 0;
    pend = '{x: 0, y: 0, c: 0};
    reset = 1; i_PLOT = 0; i_X = 0; i_Y = 0; i_COLOR = 0; i_WAITREQUEST = 0;
    @(posedge clk); @(negedge clk);
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);
    chk("rst_wr_en", int'(o_WR_EN), 0);
    chk("rst_addr", int'(o_ADDR), 0);
    chk("rst_data", int'(o_DATA), 0);
    chk("rst_full", int'(o_FULL), 0);
    chk("rst_ovf", int'(o_OVERFLOW), 0);
    chk("rst_idle", int'(o_IDLE), 1);

    // single pixel latency
    cyc(1, 5, 2, 3, 0, 0);
    chk("lat_c1_wr_en", int'(o_WR_EN), 0);
    idle_cycles(1, 0);
    chk("lat_c2_wr_en", int'(o_WR_EN), 1);
    chk("lat_c2_addr", int'(o_ADDR), 645);
    chk("lat_c2_data", int'(o_DATA), 3);
    idle_cycles(1, 0);
    chk("lat_c3_wr_en", int'(o_WR_EN), 0);
    chk("lat_c3_idle", int'(o_IDLE), 1);

    // back-to-back stream
    w0 = n_wr;
    for (int i = 0; i < 10; i++) cyc(1, i, 0, i % 8, 0, 0);
    idle_cycles(4, 0);
    chk("stream_writes", n_wr - w0, 10);
    chk("stream_last", last_addr, 9);
    chk("stream_ovf", int'(o_OVERFLOW), 0);

    // back-pressure
    for (int i = 0; i < DEPTH + 2; i++) cyc(1, 10 + i, 1, i % 8, 1, 0);
    chk("bp_full", int'(o_FULL), 1);
    chk("bp_ovf", int'(o_OVERFLOW), 1);
    chk("bp_addr_held", int'(o_ADDR), SW + 10);
    w0 = n_wr;
    idle_cycles(DEPTH + 5, 0);
    chk("bp_writes", n_wr - w0, DEPTH + 1);
    chk("bp_last", last_addr, SW + 10 + DEPTH);

    // corner address
    cyc(1, 319, 239, 7, 0, 0);
    idle_cycles(3, 0);
    chk("corner_addr", last_addr, 76799);

    // off-screen column
    w0 = n_wr;
    cyc(1, 320, 0, 2, 0, 0);
    chk("clip_idle_c1", int'(o_IDLE), on_screen(320, 0) ? 0 : 1);
    idle_cycles(3, 0);
`ifdef LDA_PIXEL_CLIP_EN
    chk("clip_writes", n_wr - w0, 0);
`else
    chk("clip_writes", n_wr - w0, 1);
    chk("clip_addr", last_addr, 320);
`endif

    // reset while a write is stalled
    for (int i = 0; i < 3; i++) cyc(1, i, 3, 1, 1, 0);
    idle_cycles(2, 1);
    cyc(0, 0, 0, 0, 1, 1);
    chk("mid_rst_wr_en", int'(o_WR_EN), 0);
    chk("mid_rst_idle", int'(o_IDLE), 1);
    w0 = n_wr;
    idle_cycles(6, 0);
    chk("mid_rst_stale", n_wr - w0, 0);

    // random traffic
    for (int i = 0; i < 400; i++)
      cyc(1'($urandom_range(0, 1)), int'($urandom_range(0, 330)),
          int'($urandom_range(0, 250)), int'($urandom_range(0, 7)),
          ($urandom_range(0, 2) == 0), 0);
    idle_cycles(DEPTH + 4, 0);
    chk("rand_drained_idle", int'(o_IDLE), 1);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
